// File: rtl/syn_fifo_flags.sv
// Synchronous FIFO with occupancy count and full/empty/almost/error flags.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module syn_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic                     r_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_acc, wr_acc;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  always_comb begin
    rd_acc   = rd_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, rd_acc};
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = wr_en && full && !rd_acc;
    unf_d = rd_en && empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q[PW-1:0]] <= w_data;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  assign r_data  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign r_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = rd_acc;
    if (rd_acc) begin
      r_data_d = mem_q[rd_ptr_q[PW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Directed scoreboard bench for syn_fifo_flags, registered-read build.
// Model FIFO feeds an expected-read queue checked against r_valid/r_data.
module tb_syn_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] w_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full, empty, almost_full, almost_empty;
  logic       overflow, underflow;
  logic [4:0] count;

  syn_fifo_flags #(
    .DATA_WIDTH(8), .DEPTH(16),
    .AFULL_THRESH(12), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .w_data(w_data),
    .rd_en(rd_en), .r_data(r_data), .r_valid(r_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow),
    .count(count)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  int         mcount = 0;
  logic [7:0] last_rd = '0;
  logic       e_ovf = 1'b0;
  logic       e_unf = 1'b0;
  logic       e_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d,
                      input logic r, input logic rs);
    bit racc, wacc;
    @(negedge clk);
    wr_en = w; w_data = d; rd_en = r; rst = rs;
    if (rs) begin
      model_q.delete();
      exp_q.delete();
      mcount = 0;
      e_ovf = 1'b0; e_unf = 1'b0; e_rv = 1'b0;
      last_rd = '0;
    end else begin
      racc = r && (mcount != 0);
      wacc = w && ((mcount != 16) || racc);
      e_ovf = w && (mcount == 16) && !racc;
      e_unf = r && (mcount == 0);
      e_rv = racc;
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
      mcount = mcount + int'(wacc) - int'(racc);
    end
    @(posedge clk);
    #1;
    chk("r_valid", 32'(r_valid), 32'(e_rv));
    if (r_valid) begin
      if (exp_q.size() == 0) chk("spurious_read", 32'(1), 32'(0));
      else last_rd = exp_q.pop_front();
    end
    chk("r_data", 32'(r_data), 32'(last_rd));
    chk("count", 32'(count), 32'(mcount));
    chk("full", 32'(full), 32'(mcount == 16));
    chk("empty", 32'(empty), 32'(mcount == 0));
    chk("almost_full", 32'(almost_full), 32'(mcount >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("underflow", 32'(underflow), 32'(e_unf));
  endtask

  initial begin
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);

    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);

    step(1, 8'hAA, 0, 0);
    step(0, 8'h00, 0, 0);

    step(1, 8'hBB, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    step(1, 8'h5A, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h30 + i), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    for (int i = 0; i < 8; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(1, 8'hEE, 0, 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
